rr_decode_arbiter: RTL and testbench
====================================

# rr_decode_arbiter

Round-robin arbiter that shares the 3-to-8 decoder among eight requesters. It picks one requester, drives the decoder's `enable` and 3-bit `in` select, and mirrors the resulting one-hot grant. It holds that grant until the requester releases it, then rotates priority. It sits directly in front of the decoder instance and owns its `enable`/`in` inputs exclusively.

## Interface
- `HOLD_MAX`, 16: maximum grant length in cycles when timeout is compiled in; legal range 2..255.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on `clk` rising edge.
- `req` input 8: level request per requester; held high for the whole transaction.
- `dec_enable` output 1: registered; drives the decoder `enable`.
- `dec_in` output 3: registered; drives the decoder `in`; index of the granted requester.
- `gnt` output 8: registered one-hot grant, equal to `dec_enable ? (8'b1 << dec_in) : 8'h00`.
- `busy` output 1: high while in the GRANT state.
- `timeout` output 1: one-cycle pulse on a forced release; tied 0 without `ARB_TIMEOUT_EN`.

## Operation
- **States:** IDLE, GRANT.
- **Reset (`rst_n`=0 at an edge):** all outputs and internal state are cleared.
  - State returns to IDLE.
  - `dec_enable`=0, `dec_in`=0, `gnt`=0, `busy`=0, `timeout`=0.
  - Priority pointer `ptr`=0, hold counter=0, mask=0.
  - Reset mid-grant drops the grant at that edge, with no timeout pulse.
- **Eligibility:** `elig = req & ~mask`.
- **Winner:** the first set bit of `elig`, searching `ptr`, `ptr`+1, … `ptr`+7, with indices taken mod 8.
- **IDLE:**
  - If `elig` is nonzero, the next edge moves to GRANT.
  - On that edge: `dec_in`=winner, `dec_enable`=1, `ptr`=winner+1 (mod 8; 7 wraps to 0).
- **GRANT release:** release occurs when `req[dec_in]`=0, sampled at an edge.
  - If `elig` is nonzero, the next winner is granted at that same edge, with no idle gap.
  - Otherwise the block returns to IDLE with `dec_enable`=0.
  - `dec_in` keeps its last value when disabled.
- **Grant stability:** `dec_in` never changes while `dec_enable` stays 1, except at a release edge.
- **Simultaneous events:**
  - A new request arriving on a release edge is eligible in that edge's search.
  - A requester that releases and re-requests on the next cycle is simply served again in its rotation slot.
- **Mask bit:** set only by timeout; `mask[i]` clears on any edge where `req[i]`=0.

## Timing
- **Request to grant:** 1 cycle.
  - `req` rising before edge N gives `dec_enable`/`gnt` at edge N.
  - The decoder output is valid combinationally after edge N.
- **Release to next grant:** 1 cycle; `req[i]` dropping before edge N switches the grant at edge N.
- **Back-to-back handover:** no dead cycle between grants when other requests are pending.
- **Rotation:** with all eight `req` held and each releasing after one grant cycle, the grants run 0,1,…,7,0.
- **Fairness:** each requester waits at most 7 grant periods.
- **Output relationships:** `busy` equals `dec_enable` in the same cycle. `gnt` changes only at clock edges.

## Configuration
- **`ARB_TIMEOUT_EN` defined:**
  - A hold counter starts at 0 on each new grant.
  - It increments every GRANT cycle.
  - If it reaches `HOLD_MAX`-1 while `req[dec_in]` is still 1, the next edge force-releases the grant:
    - `mask[dec_in]` is set.
    - `timeout`=1 for that one cycle.
    - The arbiter re-arbitrates in the same edge, with the masked requester excluded.
  - Maximum grant length is therefore `HOLD_MAX` cycles.
- **`ARB_TIMEOUT_EN` undefined:**
  - No counter and no mask logic; mask is constant 0.
  - `timeout` is tied to 0.
  - A grant is held indefinitely while its `req` stays high.

## Test plan
- **Reset:** hold `rst_n`=0 with `req`=8'hFF for 3 cycles.
  - Required: `dec_enable`=0, `gnt`=8'h00, `dec_in`=0, `busy`=0.
  - Release reset → next edge `dec_in`=0, `gnt`=8'h01.
- **Rotation:** `req`=8'hFF, with each granted requester dropping its `req` for 1 cycle after its grant.
  - Required: grants in order 0,1,…,7,0, with no cycle where `dec_enable`=0.
- **Single request and wrap:**
  - `req`=8'h80 → `dec_in`=7, `gnt`=8'h80.
  - Drop it, then `req`=8'h81 → `dec_in`=0 (pointer wrapped).
- **Mid-grant reset:** grant to requester 4, then `rst_n`=0 for 1 cycle.
  - Required: `gnt`=0 at that edge.
  - After reset, with `req`=8'h14 still held, the grant goes to 2 (pointer back to 0).
- **Timeout (`ARB_TIMEOUT_EN`, `HOLD_MAX`=4):** `req`=8'h03 held constantly.
  - Required: requester 0 is granted for 4 cycles, then `timeout` pulses and `gnt`=8'h02.
  - Requester 0 is not granted again until it drops `req` once.
- **No timeout (macro undefined):** the same stimulus keeps `gnt`=8'h01 for 100 cycles, with `timeout`=0 throughout.

Source files
------------

// File: rtl/rr_decode_arbiter_if.sv
// Handshake bundle between the eight requesters and the decoder-owning arbiter.
interface rr_decode_arbiter_if;
    logic [7:0] req;
    logic       dec_enable;
    logic [2:0] dec_in;
    logic [7:0] gnt;
    logic       busy;
    logic       timeout;

    modport master (output req, input dec_enable, dec_in, gnt, busy, timeout);
    modport slave  (input req, output dec_enable, dec_in, gnt, busy, timeout);
endinterface

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter owning the 3-to-8 decoder enable/select; grants held until release.
// Optional forced release after HOLD_MAX cycles is compiled in with ARB_TIMEOUT_EN.
module rr_decode_arbiter #(
    parameter int HOLD_MAX = 16
) (
    input logic                clk,
    input logic                rst_n,
    rr_decode_arbiter_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold
        $error("rr_decode_arbiter: HOLD_MAX must be in 2..255");
    end

    state_t     state, state_n;
    logic [2:0] ptr, ptr_n;
    logic [2:0] dec_in_q, dec_in_n;
    logic       en_q, en_n;
    logic [7:0] gnt_q, gnt_n;
    logic       to_q, to_n;
    logic [7:0] mask, excl, elig;
    logic       forced, rel, found;
    logic [2:0] win, idx;
    logic       new_grant;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt, cnt_n;
    logic [7:0] mask_n;

    assign forced = (state == GRANT) && bus.req[dec_in_q] && (cnt == 8'(HOLD_MAX - 1));
`else
    assign forced = 1'b0;
    assign mask   = 8'h00;
`endif

    // A forced-out requester is excluded from the re-arbitration on the same edge.
    assign excl = forced ? (8'h01 << dec_in_q) : 8'h00;
    assign elig = bus.req & ~mask & ~excl;
    assign rel  = (state == GRANT) && (!bus.req[dec_in_q] || forced);

    // Descending scan so the smallest offset from ptr overwrites the rest.
    always_comb begin
        win   = 3'd0;
        found = 1'b0;
        idx   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            idx = ptr + 3'(i);
            if (elig[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 3'd0;
            dec_in_q <= 3'd0;
            en_q     <= 1'b0;
            gnt_q    <= 8'h00;
            to_q     <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            dec_in_q <= dec_in_n;
            en_q     <= en_n;
            gnt_q    <= gnt_n;
            to_q     <= to_n;
        end
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        dec_in_n  = dec_in_q;
        en_n      = en_q;
        new_grant = 1'b0;
        to_n      = forced;
        if (state == IDLE || rel) begin
            if (found) begin
                state_n   = GRANT;
                en_n      = 1'b1;
                dec_in_n  = win;
                ptr_n     = win + 3'd1;
                new_grant = 1'b1;
            end else begin
                state_n = IDLE;
                en_n    = 1'b0;
            end
        end
        gnt_n = en_n ? (8'h01 << dec_in_n) : 8'h00;
    end

`ifdef ARB_TIMEOUT_EN
    always_comb begin
        mask_n = (mask & bus.req) | excl;
        if (new_grant || state_n == IDLE) cnt_n = 8'd0;
        else                              cnt_n = cnt + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= 8'd0;
            mask <= 8'h00;
        end else begin
            cnt  <= cnt_n;
            mask <= mask_n;
        end
    end
`endif

    assign bus.dec_enable = en_q;
    assign bus.dec_in     = dec_in_q;
    assign bus.gnt        = gnt_q;
    assign bus.busy       = (state == GRANT);
    assign bus.timeout    = to_q;
endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed + random bench for rr_decode_arbiter against a cycle-level behavioural model.
module tb_rr_decode_arbiter;
    localparam int H = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    rr_decode_arbiter_if bus ();

    rr_decode_arbiter #(.HOLD_MAX(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference state: who holds the grant, where the search starts, how long held, who is masked.
    bit       m_en;
    int       m_idx, m_ptr, m_cnt;
    bit [7:0] m_mask;
    bit       m_to;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit [7:0] r, input bit rn);
        bit       frc;
        bit [7:0] ex, e;
        int       w;
        if (!rn) begin
            m_en = 0; m_idx = 0; m_ptr = 0; m_cnt = 0; m_mask = 0; m_to = 0;
        end else begin
            frc  = TO_EN && m_en && r[m_idx] && (m_cnt == H - 1);
            ex   = frc ? (8'd1 << m_idx) : 8'd0;
            e    = r & ~m_mask & ~ex;
            m_to = frc;
            if (!m_en || !r[m_idx] || frc) begin
                w = -1;
                for (int k = 0; k < 8; k++)
                    if (w < 0 && e[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
                if (w >= 0) begin
                    m_en = 1; m_idx = w; m_ptr = (w + 1) % 8; m_cnt = 0;
                end else begin
                    m_en = 0;
                end
            end else begin
                m_cnt++;
            end
            if (TO_EN) m_mask = (m_mask & r) | ex;
        end
    endtask

    task automatic step(input logic [7:0] r, input logic rn);
        logic [7:0] eg;
        @(negedge clk);
        bus.req = r;
        rst_n   = rn;
        @(posedge clk);
        model_edge(r, rn);
        #1;
        eg = m_en ? (8'd1 << m_idx) : 8'd0;
        chk("gnt", bus.gnt, eg);
        chk("dec_in", {5'd0, bus.dec_in}, 8'(m_idx));
        chk("dec_enable", {7'd0, bus.dec_enable}, {7'd0, m_en});
        chk("busy", {7'd0, bus.busy}, {7'd0, m_en});
        chk("timeout", {7'd0, bus.timeout}, {7'd0, m_to});
    endtask

    initial begin
        logic [7:0] r;
        logic       rn;
        bus.req = 8'h00;

        // Reset held with all requests asserted
        for (int i = 0; i < 3; i++) step(8'hFF, 1'b0);
        chk("rst_gnt", bus.gnt, 8'h00);
        chk("rst_dec_in", {5'd0, bus.dec_in}, 8'h00);
        chk("rst_en", {7'd0, bus.dec_enable}, 8'h00);
        step(8'hFF, 1'b1);
        chk("first_gnt", bus.gnt, 8'h01);

        // Rotation: holder drops its request for one cycle after each grant
        for (int k = 1; k <= 8; k++) begin
            step(~(8'd1 << ((k - 1) % 8)), 1'b1);
            chk("rot_idx", {5'd0, bus.dec_in}, 8'(k % 8));
            chk("rot_en", {7'd0, bus.dec_enable}, 8'h01);
        end

        // Single request and pointer wrap
        step(8'h00, 1'b0);
        step(8'h80, 1'b1);
        chk("wrap7", bus.gnt, 8'h80);
        step(8'h00, 1'b1);
        step(8'h81, 1'b1);
        chk("wrap0", {5'd0, bus.dec_in}, 8'h00);

        // Mid-grant reset
        step(8'h00, 1'b0);
        step(8'h10, 1'b1);
        chk("grant4", bus.gnt, 8'h10);
        step(8'h14, 1'b0);
        chk("midrst_gnt", bus.gnt, 8'h00);
        step(8'h14, 1'b1);
        chk("after_rst", bus.gnt, 8'h04);

        // Long hold with two requesters
        step(8'h00, 1'b0);
        step(8'h03, 1'b1);
        chk("hold_start", bus.gnt, 8'h01);
        if (TO_EN) begin
            for (int i = 0; i < H - 1; i++) step(8'h03, 1'b1);
            chk("pre_to_gnt", bus.gnt, 8'h01);
            step(8'h03, 1'b1);
            chk("to_gnt", bus.gnt, 8'h02);
            chk("to_pulse", {7'd0, bus.timeout}, 8'h01);
            for (int i = 0; i < 10; i++) begin
                step(8'h03, 1'b1);
                chk("masked0", {7'd0, bus.gnt[0]}, 8'h00);
            end
            step(8'h02, 1'b1);
            step(8'h03, 1'b1);
            chk("unmasked0", bus.gnt, 8'h01);
        end else begin
            for (int i = 0; i < 100; i++) begin
                step(8'h03, 1'b1);
                chk("no_to_gnt", bus.gnt, 8'h01);
                chk("no_to_pulse", {7'd0, bus.timeout}, 8'h00);
            end
        end

        // Random sticky requests with occasional reset
        r = 8'h00;
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
            rn = ($urandom_range(0, 49) != 0);
            step(r, rn);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
